spi_flash_responder: RTL and testbench

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_responder.sv | 197 +++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial flash responder: READ (0x03), RDSR (0x05) and RDID (0x9F)
// served from a backdoor-preloaded byte array, all logic in the clk domain.
module spi_flash_responder #(
  parameter int ADDR_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cmd_err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STAT, ID, IGNORE} state_t;

  localparam logic [7:0] SETTLE = 8'(SYNC_STAGES);

  state_t                   state_r;
  logic [SYNC_STAGES-1:0]   sck_sync_r, cs_sync_r, mosi_sync_r;
  logic                     sck_d_r;
  logic                     sck_s, cs_s, mosi_s, sck_rise_s, sck_fall_s;
  logic [7:0]               settle_r;
  logic                     armed_r;
  logic [4:0]               bit_cnt_r;
  logic [6:0]               shift_r;
  logic [ADDR_W-2:0]        addr_sr_r;
  logic [ADDR_W-1:0]        rd_addr_r;
  logic [7:0]               rd_data_r;
  logic [7:0]               tx_r;
  logic [2:0]               tx_cnt_r;
  logic [1:0]               id_idx_r;
  logic [7:0]               next_byte_s;
  logic [7:0]               opcode_s;
  logic                     miso_r, oe_r, busy_r, cmd_err_r;
  logic [7:0]               mem_r [0:(1<<ADDR_W)-1];

  // Input synchronizers, reset to bus-idle levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_r  <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sck_d_r     <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], spi_sck};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      sck_d_r     <= sck_s;
    end
  end

  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign cs_s       = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_d_r;
  assign sck_fall_s = ~sck_s & sck_d_r;
  assign opcode_s   = {shift_r, mosi_s};

  // Array: no reset; a same-cycle write leaves the registered read with old data.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_r[mem_waddr] <= mem_wdata;
    end
    rd_data_r <= mem_r[rd_addr_r];
  end

  // Byte source for the next output byte in the driving states.
  always_comb begin
    next_byte_s = 8'h00;
    case (state_r)
      DATA: next_byte_s = rd_data_r;
      ID: begin
        case (id_idx_r)
          2'd0:    next_byte_s = 8'h9D;
          2'd1:    next_byte_s = 8'h70;
          2'd2:    next_byte_s = 8'h16;
          default: next_byte_s = 8'h00;
        endcase
      end
      default: next_byte_s = 8'h00;
    endcase
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      settle_r  <= 8'd0;
      armed_r   <= 1'b0;
      bit_cnt_r <= 5'd0;
      shift_r   <= 7'd0;
      addr_sr_r <= '0;
      rd_addr_r <= '0;
      tx_r      <= 8'd0;
      tx_cnt_r  <= 3'd0;
      id_idx_r  <= 2'd0;
      miso_r    <= 1'b0;
      oe_r      <= 1'b0;
      busy_r    <= 1'b0;
      cmd_err_r <= 1'b0;
    end else begin
      cmd_err_r <= 1'b0;
      if (settle_r != SETTLE) begin
        settle_r <= settle_r + 8'd1;
      end
      if (state_r != IDLE && cs_s) begin
        state_r   <= IDLE;
        bit_cnt_r <= 5'd0;
        miso_r    <= 1'b0;
        oe_r      <= 1'b0;
        busy_r    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            // Arm only after a settled high cs_n, so a low held across reset is not a new select.
            armed_r <= (settle_r == SETTLE) && cs_s;
            if (armed_r && !cs_s) begin
              state_r   <= CMD;
              bit_cnt_r <= 5'd0;
              busy_r    <= 1'b1;
            end
          end
          CMD: begin
            if (sck_rise_s) begin
              shift_r   <= opcode_s[6:0];
              bit_cnt_r <= bit_cnt_r + 5'd1;
              if (bit_cnt_r == 5'd7) begin
                bit_cnt_r <= 5'd0;
                tx_cnt_r  <= 3'd0;
                id_idx_r  <= 2'd0;
                case (opcode_s)
                  8'h03:   state_r <= ADDR;
                  8'h05:   state_r <= STAT;
                  8'h9F:   state_r <= ID;
                  default: begin
                    state_r   <= IGNORE;
                    cmd_err_r <= 1'b1;
                  end
                endcase
              end
            end
          end
          ADDR: begin
            if (sck_rise_s) begin
              addr_sr_r <= {addr_sr_r[ADDR_W-3:0], mosi_s};
              bit_cnt_r <= bit_cnt_r + 5'd1;
              if (bit_cnt_r == 5'd23) begin
                rd_addr_r <= {addr_sr_r, mosi_s};
                bit_cnt_r <= 5'd0;
                state_r   <= DATA;
              end
            end
          end
          DATA, STAT, ID: begin
            if (sck_fall_s) begin
              oe_r     <= 1'b1;
              tx_cnt_r <= tx_cnt_r + 3'd1;
              if (tx_cnt_r == 3'd0) begin
                miso_r <= next_byte_s[7];
                tx_r   <= {next_byte_s[6:0], 1'b0};
                // Prefetch the following byte while this one shifts out.
                if (state_r == DATA) begin
                  rd_addr_r <= rd_addr_r + ADDR_W'(1);
                end
                if (state_r == ID && id_idx_r != 2'd3) begin
                  id_idx_r <= id_idx_r + 2'd1;
                end
              end else begin
                miso_r <= tx_r[7];
                tx_r   <= {tx_r[6:0], 1'b0};
              end
            end
          end
          IGNORE: oe_r <= 1'b0;
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            oe_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi_miso    = miso_r;
  assign spi_miso_oe = oe_r;
  assign busy        = busy_r;
  assign cmd_err     = cmd_err_r;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: an SPI master drives transactions and
// queues expected MISO bytes; an independent monitor deserializes and compares.
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, busy, cmd_err;
  logic        mem_we = 1'b0;
  logic [11:0] mem_waddr = 12'd0;
  logic [7:0]  mem_wdata = 8'd0;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q [$];
  int          err_cnt = 0;
  int          oe_cnt = 0;

  spi_flash_responder #(.ADDR_W(12), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_err) err_cnt <= err_cnt + 1;
    if (spi_miso_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: master-side sampling on SCK rise while the responder drives.
  initial begin
    logic [7:0] sr;
    logic [7:0] e;
    int         cnt;
    cnt = 0;
    sr  = 8'd0;
    forever begin
      @(posedge spi_sck or posedge spi_cs_n or posedge rst);
      if (spi_cs_n || rst) begin
        cnt = 0;
      end else if (spi_miso_oe) begin
        sr = {sr[6:0], spi_miso};
        cnt++;
        if (cnt == 8) begin
          cnt = 0;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL miso_byte: got 0x%0h expected no byte", sr);
          end else begin
            e = exp_q.pop_front();
            if (sr !== e) begin
              n_err++;
              $display("FAIL miso_byte: got 0x%0h expected 0x%0h", sr, e);
            end
          end
        end
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = v[i];
      #50 spi_sck = 1'b1;
      #50 spi_sck = 1'b0;
    end
    spi_mosi = 1'b0;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    #50 spi_cs_n = 1'b1;
    #200;
  endtask

  task automatic do_read(input logic [23:0] a, input int nbytes);
    cs_low();
    send_bits(32'h03, 8);
    send_bits({8'h00, a}, 24);
    send_bits(32'h0, nbytes * 8);
    cs_high();
  endtask

  initial begin
    int t0;
    int o0;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int e0, o0;
    @(negedge clk);
    #20;
    check("reset_outputs", {28'd0, spi_miso, spi_miso_oe, busy, cmd_err}, 32'd0);
    rst = 1'b0;
    preload(12'h010, 8'hA5);
    preload(12'h011, 8'h3C);
    preload(12'hFFF, 8'h11);
    preload(12'h000, 8'h22);
    #200;
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Basic READ, oe must stay low through the address phase.
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    cs_low();
    check("busy_after_cs", {31'd0, busy}, 32'd1);
    send_bits(32'h03, 8);
    send_bits(32'h0000, 16);
    check("oe_in_addr", {31'd0, spi_miso_oe}, 32'd0);
    send_bits(32'h10, 8);
    send_bits(32'h0, 16);
    cs_high();
    check("oe_after_cs", {31'd0, spi_miso_oe}, 32'd0);

    // Address wrap and upper address bits discarded.
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    do_read(24'h000FFF, 2);
    exp_q.push_back(8'hA5);
    do_read(24'hABC010, 1);

    // RDID and RDSR.
    exp_q.push_back(8'h9D); exp_q.push_back(8'h70);
    exp_q.push_back(8'h16); exp_q.push_back(8'h00);
    cs_low(); send_bits(32'h9F, 8); send_bits(32'h0, 32); cs_high();
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    cs_low(); send_bits(32'h05, 8); send_bits(32'h0, 16); cs_high();

    // Unsupported opcode.
    e0 = err_cnt; o0 = oe_cnt;
    cs_low(); send_bits(32'h5A, 8); send_bits(32'hFF, 8);
    #50 spi_cs_n = 1'b1;
    #1;
    check("busy_at_cs_rise", {31'd0, busy}, 32'd1);
    #100;
    check("busy_after_cs_rise", {31'd0, busy}, 32'd0);
    check("cmd_err_pulses", err_cnt - e0, 32'd1);
    check("ignore_oe", oe_cnt - o0, 32'd0);
    #150;
    exp_q.push_back(8'h3C);
    do_read(24'h000011, 1);

    // Partial address abort, then a clean READ.
    cs_low(); send_bits(32'h03, 8); send_bits(32'h1FFF, 13); cs_high();
    exp_q.push_back(8'hA5);
    do_read(24'h000010, 1);

    // Reset in the middle of DATA.
    cs_low(); send_bits(32'h03, 8); send_bits(32'h10, 24); send_bits(32'h0, 4);
    rst = 1'b1;
    #1;
    check("rst_mid_data", {28'd0, spi_miso, spi_miso_oe, busy, cmd_err}, 32'd0);
    #49 rst = 1'b0;
    o0 = oe_cnt;
    send_bits(32'h0, 16);
    check("post_rst_oe", oe_cnt - o0, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    cs_high();
    exp_q.push_back(8'hA5);
    do_read(24'h000010, 1);

    #200;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
